// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_pkg
//  Description : Shared definitions for the data-memory arbiter. Holds the
//                FSM state encoding, the port identifiers, the significant
//                memory address width and the latched transaction record.
//  Revision    : 1.0 - initial release
// ============================================================================
package dmem_pkg;

  // Only the low DMEM_AW bits of a requester address reach the memory.
  localparam int DMEM_AW = 8;

  // Arbiter FSM encoding.
  localparam logic [1:0] c_ST_IDLE   = 2'd0;
  localparam logic [1:0] c_ST_SETUP  = 2'd1;
  localparam logic [1:0] c_ST_STROBE = 2'd2;
  localparam logic [1:0] c_ST_DONE   = 2'd3;

  // Port identifiers, also used as the round-robin "last granted" value.
  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  // Everything about a transaction that is frozen at grant time.
  typedef struct packed {
    logic               owner;
    logic               we;
    logic [DMEM_AW-1:0] addr;
    logic [31:0]        wdata;
  } dmem_txn_t;

  // Zero-extend a word address onto the 32-bit memory address bus.
  function automatic logic [31:0] dmem_word_addr(input logic [DMEM_AW-1:0] a);
    return {{(32-DMEM_AW){1'b0}}, a};
  endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_rr_pick
//  Description : Combinational two-port grant decision. With RR_EN=1 a tie
//                goes to the port that was not granted last; with RR_EN=0
//                port A always wins a tie. A sole requester always wins.
//  Ports       : i_a_req  - port A request
//                i_b_req  - port B request
//                i_last   - port granted most recently (PORT_A / PORT_B)
//                o_valid  - at least one port is requesting
//                o_port   - chosen port (meaningful only when o_valid=1)
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_rr_pick
  import dmem_pkg::*;
#(
  parameter bit RR_EN = 1'b1
) (
  input  logic i_a_req,
  input  logic i_b_req,
  input  logic i_last,
  output logic o_valid,
  output logic o_port
);

  always_comb begin
    o_valid = i_a_req | i_b_req;
    o_port  = PORT_A;
    if (i_a_req && i_b_req) begin
      if (RR_EN) begin
        o_port = (i_last == PORT_A) ? PORT_B : PORT_A;
      end else begin
        o_port = PORT_A;
      end
    end else if (i_b_req) begin
      o_port = PORT_B;
    end
  end

endmodule
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_arbiter
//  Description : Two-port arbiter in front of a single-port data memory.
//                Each access runs IDLE -> SETUP -> STROBE -> DONE; the
//                request is latched at grant and the requester may drop or
//                change its inputs afterwards without effect.
//  Ports       : clk, rst_n          - clock, async active-low reset
//                a_* / b_*           - requester ports (req, we, addr, wdata
//                                      in; ack pulse and rdata out)
//                DMEM_address        - memory word address (bits [31:8] = 0)
//                DMEM_data_in        - memory write data
//                DMEM_mem_write      - write strobe, memory writes on its
//                                      rising edge
//                DMEM_mem_read       - read enable
//                DMEM_data_out       - combinational read data from memory
//                busy                - an access is in progress
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter bit RR_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,

  input  logic        a_req,
  input  logic        a_we,
  input  logic [31:0] a_addr,
  input  logic [31:0] a_wdata,
  output logic        a_ack,
  output logic [31:0] a_rdata,

  input  logic        b_req,
  input  logic        b_we,
  input  logic [31:0] b_addr,
  input  logic [31:0] b_wdata,
  output logic        b_ack,
  output logic [31:0] b_rdata,

  output logic [31:0] DMEM_address,
  output logic [31:0] DMEM_data_in,
  output logic        DMEM_mem_write,
  output logic        DMEM_mem_read,
  input  logic [31:0] DMEM_data_out,

  output logic        busy
);

  logic [1:0]  r_state;
  logic [1:0]  w_next_state;
  dmem_txn_t   r_txn;
  dmem_txn_t   w_cap;
  logic        r_last;
  logic        r_mem_write;
  logic [31:0] r_rdata;

  logic        w_grant_valid;
  logic        w_grant_port;
  logic        w_grant;
  logic        w_drive;
  logic        w_done;

  // Upper address bits wrap away by design.
  logic        w_unused_addr_hi;
  assign w_unused_addr_hi = ^{a_addr[31:DMEM_AW], b_addr[31:DMEM_AW]};

  // --------------------------------------------------------------------------
  // Arbitration
  // --------------------------------------------------------------------------
  dmem_rr_pick #(
    .RR_EN   (RR_EN)
  ) u_pick (
    .i_a_req (a_req),
    .i_b_req (b_req),
    .i_last  (r_last),
    .o_valid (w_grant_valid),
    .o_port  (w_grant_port)
  );

  assign w_grant = (r_state == c_ST_IDLE) && w_grant_valid;

  always_comb begin
    w_cap.owner = w_grant_port;
    if (w_grant_port == PORT_B) begin
      w_cap.we    = b_we;
      w_cap.addr  = b_addr[DMEM_AW-1:0];
      w_cap.wdata = b_wdata;
    end else begin
      w_cap.we    = a_we;
      w_cap.addr  = a_addr[DMEM_AW-1:0];
      w_cap.wdata = a_wdata;
    end
  end

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_ST_IDLE:   if (w_grant_valid) w_next_state = c_ST_SETUP;
      c_ST_SETUP:  w_next_state = c_ST_STROBE;
      c_ST_STROBE: w_next_state = c_ST_DONE;
      c_ST_DONE:   w_next_state = c_ST_IDLE;
      default:     w_next_state = c_ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Transaction latch and round-robin pointer move only on a grant. After
  // reset the pointer reads "B last" so that the first tie goes to A.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_txn  <= '0;
      r_last <= PORT_B;
    end else if (w_grant) begin
      r_txn  <= w_cap;
      r_last <= w_grant_port;
    end
  end

  // The write strobe comes straight from a flop so the memory sees exactly
  // one clean rising edge, one cycle after address and data were presented.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem_write <= 1'b0;
    end else begin
      r_mem_write <= (w_next_state == c_ST_STROBE) && r_txn.we;
    end
  end

  // Read data is sampled at the end of STROBE; writes return zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata <= '0;
    end else if (r_state == c_ST_STROBE) begin
      r_rdata <= r_txn.we ? 32'h0 : DMEM_data_out;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign w_drive = (r_state == c_ST_SETUP) || (r_state == c_ST_STROBE);
  assign w_done  = (r_state == c_ST_DONE);

  assign DMEM_address   = w_drive ? dmem_word_addr(r_txn.addr) : 32'h0;
  assign DMEM_data_in   = w_drive ? r_txn.wdata : 32'h0;
  assign DMEM_mem_write = r_mem_write;
  assign DMEM_mem_read  = w_drive && !r_txn.we;

  assign a_ack   = w_done && (r_txn.owner == PORT_A);
  assign b_ack   = w_done && (r_txn.owner == PORT_B);
  assign a_rdata = a_ack ? r_rdata : 32'h0;
  assign b_rdata = b_ack ? r_rdata : 32'h0;

  assign busy = (r_state != c_ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dmem_arbiter
//  Description : Self-checking bench for dmem_arbiter. A behavioural memory
//                is attached to the round-robin instance; a second instance
//                with fixed priority shares the requester stimulus.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;
  import dmem_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        a_req, a_we, b_req, b_we;
  logic [31:0] a_addr, a_wdata, b_addr, b_wdata;

  logic        a_ack, b_ack, busy;
  logic [31:0] a_rdata, b_rdata;
  logic [31:0] DMEM_address, DMEM_data_in, DMEM_data_out;
  logic        DMEM_mem_write, DMEM_mem_read;

  logic        fp_a_ack, fp_b_ack, fp_busy;
  logic [31:0] fp_a_rdata, fp_b_rdata, fp_addr, fp_din;
  logic        fp_wr, fp_rd;
  logic [31:0] fp_dout;
  assign fp_dout = 32'h0;

  dmem_arbiter #(.RR_EN(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_ack(a_ack), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_ack(b_ack), .b_rdata(b_rdata),
    .DMEM_address(DMEM_address), .DMEM_data_in(DMEM_data_in),
    .DMEM_mem_write(DMEM_mem_write), .DMEM_mem_read(DMEM_mem_read),
    .DMEM_data_out(DMEM_data_out), .busy(busy)
  );

  dmem_arbiter #(.RR_EN(1'b0)) u_fp (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_ack(fp_a_ack), .a_rdata(fp_a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_ack(fp_b_ack), .b_rdata(fp_b_rdata),
    .DMEM_address(fp_addr), .DMEM_data_in(fp_din),
    .DMEM_mem_write(fp_wr), .DMEM_mem_read(fp_rd),
    .DMEM_data_out(fp_dout), .busy(fp_busy)
  );

  // Memory: writes on the rising edge of the strobe, combinational read.
  logic [31:0] mem [256] = '{default: 32'h0};
  int          wr_edges = 0;
  always @(posedge DMEM_mem_write) begin
    mem[DMEM_address[7:0]] <= DMEM_data_in;
    wr_edges <= wr_edges + 1;
  end
  assign DMEM_data_out = mem[DMEM_address[7:0]];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [132:0] act,
                       input logic [132:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    a_req = 0; a_we = 0; a_addr = 0; a_wdata = 0;
    b_req = 0; b_we = 0; b_addr = 0; b_wdata = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Drive one single-port transaction and check every phase of it.
  // Called right after a negedge with the arbiter idle.
  task automatic do_txn(input logic port, input logic we,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp, input string tag);
    int   e0;
    int   t;
    logic oa, ob;
    e0 = wr_edges;
    oa = (port == PORT_A);
    ob = (port == PORT_B);
    idle_inputs();
    if (oa) begin a_req = 1; a_we = we; a_addr = addr; a_wdata = wdata; end
    else    begin b_req = 1; b_we = we; b_addr = addr; b_wdata = wdata; end
    t = 0;
    while (!busy && t < 8) begin @(negedge clk); t++; end
    check({tag, " grant"}, {busy, 32'(t)}, {1'b1, 32'd1});
    // Withdraw and scramble the request: the latched copy must be used.
    a_req = 0; b_req = 0;
    a_addr = $urandom; a_wdata = $urandom; b_addr = $urandom; b_wdata = $urandom;
    check({tag, " setup"}, {DMEM_address, DMEM_data_in, DMEM_mem_write,
          DMEM_mem_read, a_ack, b_ack},
          {{24'h0, addr[7:0]}, wdata, 1'b0, !we, 1'b0, 1'b0});
    @(negedge clk);
    check({tag, " strobe"}, {DMEM_address, DMEM_data_in, DMEM_mem_write,
          DMEM_mem_read, a_ack, b_ack},
          {{24'h0, addr[7:0]}, wdata, we, !we, 1'b0, 1'b0});
    @(negedge clk);
    check({tag, " done"}, {a_ack, b_ack, busy, DMEM_address, DMEM_mem_write,
          DMEM_mem_read}, {oa, ob, 1'b1, 32'h0, 1'b0, 1'b0});
    check({tag, " rdata"}, {a_rdata, b_rdata},
          oa ? {exp, 32'h0} : {32'h0, exp});
    check({tag, " write edges"}, 133'(wr_edges - e0), we ? 133'd1 : 133'd0);
    @(negedge clk);
    check({tag, " idle"}, {a_ack, b_ack, busy}, 3'b000);
  endtask

  typedef struct {
    logic        port;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t vt[11];

  // Reference model state for the random phase.
  int          m_cnt;
  logic        m_last, m_own, m_we;
  logic [7:0]  m_addr;
  logic [31:0] m_wdata, m_rd;
  logic [31:0] mm [256];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  ord, ford;
    int          na, nf, nacks, t, e0;
    logic [31:0] r;

    vt[0]  = '{PORT_A, 1'b1, 32'h0000_0010, 32'hDEADBEEF, 32'h0};
    vt[1]  = '{PORT_A, 1'b0, 32'h0000_0010, 32'h0,        32'hDEADBEEF};
    vt[2]  = '{PORT_B, 1'b1, 32'h0000_0020, 32'h12345678, 32'h0};
    vt[3]  = '{PORT_A, 1'b0, 32'h0000_0120, 32'h0,        32'h12345678};
    vt[4]  = '{PORT_B, 1'b1, 32'h0000_01FF, 32'hCAFEF00D, 32'h0};
    vt[5]  = '{PORT_B, 1'b0, 32'h0000_01FF, 32'h0,        32'hCAFEF00D};
    vt[6]  = '{PORT_A, 1'b1, 32'h0000_0105, 32'h00000055, 32'h0};
    vt[7]  = '{PORT_B, 1'b0, 32'h0000_0005, 32'h0,        32'h00000055};
    vt[8]  = '{PORT_A, 1'b0, 32'h0000_0044, 32'h0,        32'h0};
    vt[9]  = '{PORT_B, 1'b1, 32'hFFFF_FF00, 32'hA5A50001, 32'h0};
    vt[10] = '{PORT_A, 1'b0, 32'h0000_0000, 32'h0,        32'hA5A50001};

    // Reset state.
    idle_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    check("reset outputs", {busy, a_ack, b_ack, DMEM_mem_write, DMEM_mem_read,
          DMEM_address, DMEM_data_in, a_rdata, b_rdata}, 133'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle after reset", {busy, fp_busy}, 2'b00);

    // Directed table.
    for (int i = 0; i < 11; i++)
      do_txn(vt[i].port, vt[i].we, vt[i].addr, vt[i].wdata, vt[i].exp,
             $sformatf("vec%0d", i));
    check("mem[20] after dropped B write", mem[8'h20], 32'h12345678);

    // Both ports request continuously: RR alternates, fixed priority starves B.
    do_reset();
    a_req = 1; a_we = 0; a_addr = 32'h10;
    b_req = 1; b_we = 0; b_addr = 32'h20;
    na = 0; nf = 0; ord = '0; ford = '0;
    for (int c = 0; c < 40 && (na < 4 || nf < 4); c++) begin
      @(negedge clk);
      if ((a_ack || b_ack) && na < 4) begin
        ord[na] = b_ack;
        check("rr rdata", b_ack ? b_rdata : a_rdata,
              b_ack ? 32'h12345678 : 32'hDEADBEEF);
        na++;
      end
      if ((fp_a_ack || fp_b_ack) && nf < 4) begin
        ford[nf] = fp_b_ack;
        nf++;
      end
    end
    idle_inputs();
    check("rr grant order", {32'(na), ord}, {32'd4, 4'b1010});
    check("fixed grant order", {32'(nf), ford}, {32'd4, 4'b0000});
    @(negedge clk);

    // Reset in the middle of a write strobe.
    e0 = wr_edges;
    a_req = 1; a_we = 1; a_addr = 32'h30; a_wdata = 32'hFFFF0000;
    t = 0;
    while (!busy && t < 8) begin @(negedge clk); t++; end
    a_req = 0;
    @(negedge clk);
    check("strobe before reset", DMEM_mem_write, 1'b1);
    rst_n = 1'b0;
    #1;
    check("outputs in mid-strobe reset", {busy, a_ack, b_ack, DMEM_mem_write,
          DMEM_mem_read, DMEM_address, DMEM_data_in, a_rdata, b_rdata}, 133'h0);
    @(negedge clk);
    rst_n = 1'b1;
    nacks = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (a_ack || b_ack || busy) nacks++;
    end
    check("no ack after reset", 133'(nacks), 133'd0);
    check("single strobe edge", 133'(wr_edges - e0), 133'd1);
    a_req = 1; a_addr = 32'h10; a_we = 0;
    b_req = 1; b_addr = 32'h20; b_we = 0;
    t = 0;
    while (!(a_ack || b_ack) && t < 10) begin @(negedge clk); t++; end
    check("first tie after reset", {a_ack, b_ack}, 2'b10);
    idle_inputs();
    @(negedge clk);

    // Random traffic against a transaction-level model.
    do_reset();
    m_cnt = 0; m_last = PORT_B; m_own = PORT_A; m_we = 0;
    m_addr = 0; m_wdata = 0; m_rd = 0;
    for (int i = 0; i < 256; i++) mm[i] = 32'h0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      logic        e_drive, e_aack, e_back;
      a_req = ($urandom_range(0, 99) < 40);
      a_we  = 1'($urandom_range(0, 1));
      r = $urandom; a_addr = {r[31:8], 4'h8, r[3:0]};
      a_wdata = $urandom;
      b_req = ($urandom_range(0, 99) < 40);
      b_we  = 1'($urandom_range(0, 1));
      r = $urandom; b_addr = {r[31:8], 4'h8, r[3:0]};
      b_wdata = $urandom;
      @(posedge clk);
      if (m_cnt == 0) begin
        if (a_req || b_req) begin
          if (a_req && b_req) m_own = (m_last == PORT_B) ? PORT_A : PORT_B;
          else                m_own = a_req ? PORT_A : PORT_B;
          m_we    = (m_own == PORT_B) ? b_we : a_we;
          m_addr  = (m_own == PORT_B) ? b_addr[7:0] : a_addr[7:0];
          m_wdata = (m_own == PORT_B) ? b_wdata : a_wdata;
          m_last  = m_own;
          m_cnt   = 3;
        end
      end else begin
        m_cnt--;
        if (m_cnt == 2 && m_we) mm[m_addr] = m_wdata;
        if (m_cnt == 1) m_rd = m_we ? 32'h0 : mm[m_addr];
      end
      @(negedge clk);
      e_drive = (m_cnt == 3) || (m_cnt == 2);
      e_aack  = (m_cnt == 1) && (m_own == PORT_A);
      e_back  = (m_cnt == 1) && (m_own == PORT_B);
      check($sformatf("random cycle %0d", cyc),
            {busy, a_ack, b_ack, DMEM_mem_write, DMEM_mem_read,
             DMEM_address, DMEM_data_in, a_rdata, b_rdata},
            {(m_cnt != 0), e_aack, e_back, (m_cnt == 2) && m_we,
             e_drive && !m_we,
             e_drive ? {24'h0, m_addr} : 32'h0,
             e_drive ? m_wdata : 32'h0,
             e_aack ? m_rd : 32'h0,
             e_back ? m_rd : 32'h0});
    end
    idle_inputs();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
